// File: rtl/pid_nco.sv
// pid_nco: phase accumulator NCO whose FCW is trimmed by the PID correction, with a watchdog FSM.
// Optional output dithering is enabled by defining PID_NCO_DITHER_EN.
module pid_nco #(
  parameter int                   PHASE_WIDTH = 10,
  parameter int                   PID_OWIDTH  = 9,
  parameter int                   ACC_WIDTH   = 24,
  parameter logic [ACC_WIDTH-1:0] FCW_NOM     = ACC_WIDTH'(24'h000100),
  parameter logic [ACC_WIDTH-1:0] FCW_MIN     = '0,
  parameter logic [ACC_WIDTH-1:0] FCW_MAX     = '1,
  parameter int                   CORR_SHIFT  = 8,
  parameter int                   HOLD_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [PID_OWIDTH-1:0] pid_i,
  input  logic                         pid_valid_i,
  output logic        [PHASE_WIDTH-1:0] phase_o,
  output logic                         wrap_o,
  output logic        [ACC_WIDTH-1:0]  fcw_o,
  output logic                         locked_o,
  output logic                         holdover_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // Two guard bits so nominal + correction can never overflow before clamping.
  localparam int SW = ACC_WIDTH + 2;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam bit WD_EN = (HOLD_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  logic [1:0]           state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 load;
  logic [ACC_WIDTH-1:0] acc;
  logic                 wrap_q;

  logic signed [SW-1:0] corr, fcw_sum, nom_ext, min_ext, max_ext;
  logic [ACC_WIDTH-1:0] fcw_next;

  assign corr    = {{(SW-PID_OWIDTH){pid_i[PID_OWIDTH-1]}}, pid_i} <<< CORR_SHIFT;
  assign nom_ext = signed'({2'b00, FCW_NOM});
  assign min_ext = signed'({2'b00, FCW_MIN});
  assign max_ext = signed'({2'b00, FCW_MAX});
  assign fcw_sum = nom_ext + corr;

  always_comb begin
    if (fcw_sum < min_ext)
      fcw_next = FCW_MIN;
    else if (fcw_sum > max_ext)
      fcw_next = FCW_MAX;
    else
      fcw_next = fcw_sum[ACC_WIDTH-1:0];
  end

  // A valid strobe always wins over watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pid_valid_i) begin
          state_nxt = TRACK;
          load      = 1'b1;
        end
      end
      TRACK: begin
        if (pid_valid_i) begin
          load    = 1'b1;
          cnt_nxt = '0;
        end else if (WD_EN && (cnt == CNT_LAST)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (WD_EN) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        cnt_nxt = '0;
        if (pid_valid_i) begin
          state_nxt = TRACK;
          load      = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fcw_o      <= FCW_NOM;
      locked_o   <= 1'b0;
      holdover_o <= 1'b0;
      acc        <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      locked_o   <= (state_nxt == TRACK);
      holdover_o <= (state_nxt == HOLD);
      if (load)
        fcw_o <= fcw_next;
      {wrap_q, acc} <= {1'b0, acc} + {1'b0, fcw_o};
    end
  end

`ifdef PID_NCO_DITHER_EN
  localparam int DW_RAW = ACC_WIDTH - PHASE_WIDTH;
  localparam int DW     = (DW_RAW > 16) ? 16 : DW_RAW;
  localparam logic [ACC_WIDTH-1:0] DITH_MASK = (ACC_WIDTH'(1) << DW) - ACC_WIDTH'(1);

  logic [15:0]            lfsr;
  logic                   lfsr_fb;
  logic [ACC_WIDTH-1:0]   dith_sum;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   wrap_d;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dith_sum = acc + (ACC_WIDTH'(lfsr) & DITH_MASK);

  // Extra output stage; wrap is delayed alongside so it stays aligned with phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= 16'hACE1;
      phase_q <= '0;
      wrap_d  <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      phase_q <= dith_sum[ACC_WIDTH-1 -: PHASE_WIDTH];
      wrap_d  <= wrap_q;
    end
  end

  assign phase_o = phase_q;
  assign wrap_o  = wrap_d;
`else
  assign phase_o = acc[ACC_WIDTH-1 -: PHASE_WIDTH];
  assign wrap_o  = wrap_q;
`endif

endmodule

// File: tb/tb_pid_nco.sv
// Directed bench for pid_nco (default build): reset, free run, tracking, clamping, watchdog and reset recovery.
module tb_pid_nco;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [8:0]   pid_i;
  logic                pid_valid_i;
  logic [9:0]          phase_o;
  logic                wrap_o;
  logic [15:0]         fcw_o;
  logic                locked_o;
  logic                holdover_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pid_nco #(
    .PHASE_WIDTH (10),
    .PID_OWIDTH  (9),
    .ACC_WIDTH   (16),
    .FCW_NOM     (16'h0100),
    .FCW_MIN     (16'h0080),
    .FCW_MAX     (16'h0180),
    .CORR_SHIFT  (2),
    .HOLD_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pid_i       (pid_i),
    .pid_valid_i (pid_valid_i),
    .phase_o     (phase_o),
    .wrap_o      (wrap_o),
    .fcw_o       (fcw_o),
    .locked_o    (locked_o),
    .holdover_o  (holdover_o)
  );

  task automatic applyStimulus(input logic r, input logic v, input logic signed [8:0] p);
    rst         = r;
    pid_valid_i = v;
    pid_i       = p;
  endtask

  // Advance n rising edges and park on the following falling edge for sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("[TB] %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 9'sd0);
    step(2);
    checkOutput("rst_phase",    32'(phase_o),    32'h0);
    checkOutput("rst_wrap",     32'(wrap_o),     32'h0);
    checkOutput("rst_fcw",      32'(fcw_o),      32'h0100);
    checkOutput("rst_locked",   32'(locked_o),   32'h0);
    checkOutput("rst_holdover", 32'(holdover_o), 32'h0);

    // Free run at nominal FCW: phase advances by 4 each cycle, wraps every 256 cycles.
    applyStimulus(1'b0, 1'b0, 9'sd0);
    step(1);
    checkOutput("free_phase_1",   32'(phase_o), 32'd4);
    step(3);
    checkOutput("free_phase_4",   32'(phase_o), 32'd16);
    step(251);
    checkOutput("free_phase_255", 32'(phase_o), 32'h3FC);
    checkOutput("free_nowrap",    32'(wrap_o),  32'h0);
    step(1);
    checkOutput("free_phase_256", 32'(phase_o), 32'h0);
    checkOutput("free_wrap",      32'(wrap_o),  32'h1);
    step(1);
    checkOutput("free_phase_257", 32'(phase_o), 32'd4);
    checkOutput("free_wrap_off",  32'(wrap_o),  32'h0);
    checkOutput("free_locked",    32'(locked_o), 32'h0);
    checkOutput("free_fcw",       32'(fcw_o),   32'h0100);

    // +4 correction: fcw 0x110 next cycle, accumulator picks it up one cycle later.
    applyStimulus(1'b0, 1'b1, 9'sd4);
    step(1);
    applyStimulus(1'b0, 1'b0, 9'sd0);
    checkOutput("p4_fcw",      32'(fcw_o),      32'h0110);
    checkOutput("p4_locked",   32'(locked_o),   32'h1);
    checkOutput("p4_holdover", 32'(holdover_o), 32'h0);
    checkOutput("p4_phase_e0", 32'(phase_o),    32'd8);
    step(1);
    checkOutput("p4_phase_e1", 32'(phase_o),    32'd12);
    step(6);
    checkOutput("wd_e7_holdover", 32'(holdover_o), 32'h0);
    checkOutput("wd_e7_locked",   32'(locked_o),   32'h1);
    checkOutput("wd_e7_phase",    32'(phase_o),    32'd37);
    step(1);
    checkOutput("wd_e8_holdover", 32'(holdover_o), 32'h1);
    checkOutput("wd_e8_locked",   32'(locked_o),   32'h0);
    checkOutput("wd_e8_fcw",      32'(fcw_o),      32'h0110);
    checkOutput("wd_e8_phase",    32'(phase_o),    32'd42);
    step(1);
    checkOutput("hold_phase",     32'(phase_o),    32'd46);
    checkOutput("hold_fcw",       32'(fcw_o),      32'h0110);

    // -4 correction out of HOLD.
    applyStimulus(1'b0, 1'b1, -9'sd4);
    step(1);
    applyStimulus(1'b0, 1'b0, 9'sd0);
    checkOutput("m4_fcw",      32'(fcw_o),      32'h00F0);
    checkOutput("m4_locked",   32'(locked_o),   32'h1);
    checkOutput("m4_holdover", 32'(holdover_o), 32'h0);
    checkOutput("m4_phase_f0", 32'(phase_o),    32'd50);
    step(1);
    checkOutput("m4_phase_f1", 32'(phase_o),    32'd54);
    step(6);
    checkOutput("f7_holdover", 32'(holdover_o), 32'h0);

    // Valid on the expiry cycle, +255 saturates at FCW_MAX.
    applyStimulus(1'b0, 1'b1, 9'sd255);
    step(1);
    applyStimulus(1'b0, 1'b0, 9'sd0);
    checkOutput("exp_holdover", 32'(holdover_o), 32'h0);
    checkOutput("exp_locked",   32'(locked_o),   32'h1);
    checkOutput("clamp_max",    32'(fcw_o),      32'h0180);
    checkOutput("exp_phase",    32'(phase_o),    32'd80);
    step(1);
    checkOutput("max_phase_g1", 32'(phase_o),    32'd86);
    step(6);
    checkOutput("g7_holdover",  32'(holdover_o), 32'h0);
    checkOutput("g7_locked",    32'(locked_o),   32'h1);
    checkOutput("g7_phase",     32'(phase_o),    32'd122);

    // -256 saturates at FCW_MIN.
    applyStimulus(1'b0, 1'b1, -9'sd256);
    step(1);
    applyStimulus(1'b0, 1'b0, 9'sd0);
    checkOutput("clamp_min",    32'(fcw_o),    32'h0080);
    checkOutput("min_phase",    32'(phase_o),  32'd128);

    // Reset mid-TRACK with a strobe in flight: the strobe is discarded.
    applyStimulus(1'b1, 1'b1, 9'sd4);
    step(1);
    checkOutput("mid_rst_phase",    32'(phase_o),    32'h0);
    checkOutput("mid_rst_wrap",     32'(wrap_o),     32'h0);
    checkOutput("mid_rst_fcw",      32'(fcw_o),      32'h0100);
    checkOutput("mid_rst_locked",   32'(locked_o),   32'h0);
    checkOutput("mid_rst_holdover", 32'(holdover_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 9'sd0);
    step(1);
    checkOutput("post_rst_phase",  32'(phase_o),  32'd4);
    checkOutput("post_rst_fcw",    32'(fcw_o),    32'h0100);
    checkOutput("post_rst_locked", 32'(locked_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
